cfg_frame_loader: RTL and testbench

- Configuration loader upstream of the connection-block array.
- Accepts a serial bitstream over a valid/ready handshake and assembles it into 18-bit frames.
- Writes frames to each Cblock in turn via the shared `bits` bus and a one-hot `wr_en`.
- Sequences setup and hold around each write so the level-sensitive latches in each block capture a stable frame.

---
 rtl/cfg_frame_loader.sv | 175 +++++++++++++++++
 tb/tb_cfg_frame_loader.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_frame_loader.sv
// cfg_frame_loader
//
// Purpose: Loads configuration into the connection-block array. A serial
// bitstream arrives MSB first over a valid/ready handshake. The loader packs it
// into FRAME_W-bit frames and writes each frame to one Cblock in turn, starting
// with block 0. Each write uses the shared `bits` bus and a one-hot `wr_en`.
// Every write is framed by a SETUP cycle and a HOLD cycle. This keeps `bits`
// stable around the enable pulse, so the level-sensitive latches in the
// Cblocks capture a clean frame.
//
// Handshake: a serial bit transfers on a rising edge where cfg_valid and
// cfg_ready are both high. cfg_ready is high only in SHIFT. The ready signal
// does not depend on cfg_valid.
//
// Optional feature (macro CFG_PARITY_EN):
//   - Each frame is followed by one even-parity bit. This bit is not shifted
//     into `bits`.
//   - A parity mismatch sets err and aborts the load through DONE. The block
//     with the bad frame is not written.
//   - With the macro undefined, no parity bit is expected and err is tied to 0.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   start      one-cycle load request, honoured only in IDLE
//   cfg_valid  serial bit valid
//   cfg_bit    serial bit, frame MSB first
//   cfg_ready  loader accepts cfg_bit this cycle
//   bits       FRAME_W-bit frame bus to all Cblocks
//   wr_en      one-hot latch enable, bit i drives Cblock i
//   busy       high from accepted start until done
//   done       one-cycle pulse after the final block write
//   err        sticky parity error, cleared by reset or accepted start
module cfg_frame_loader #(
    parameter int NUM_BLOCKS = 4,
    parameter int FRAME_W    = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  cfg_valid,
    input  logic                  cfg_bit,
    output logic                  cfg_ready,
    output logic [FRAME_W-1:0]    bits,
    output logic [NUM_BLOCKS-1:0] wr_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CNT_W = $clog2(FRAME_W + 2);
    localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        SETUP = 3'd2,
        WRITE = 3'd3,
        HOLD  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] bits_q,  bits_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [IDX_W-1:0]   blk_q,   blk_d;
`ifdef CFG_PARITY_EN
    logic               err_q,   err_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bits_q  <= '0;
            cnt_q   <= '0;
            blk_q   <= '0;
`ifdef CFG_PARITY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
`ifdef CFG_PARITY_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        bits_d    = bits_q;
        cnt_d     = cnt_q;
        blk_d     = blk_q;
`ifdef CFG_PARITY_EN
        err_d     = err_q;
`endif
        cfg_ready = 1'b0;
        wr_en     = '0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    blk_d   = '0;
`ifdef CFG_PARITY_EN
                    err_d   = 1'b0;
`endif
                end
            end
            SHIFT: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
`ifdef CFG_PARITY_EN
                    // The extra bit after a full frame is parity. It is
                    // compared with the frame and never shifted into bits.
                    if (cnt_q == CNT_W'(FRAME_W)) begin
                        if (cfg_bit == ^bits_q) begin
                            state_d = SETUP;
                        end else begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end
                    end else begin
                        bits_d = {bits_q[FRAME_W-2:0], cfg_bit};
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
`else
                    bits_d = {bits_q[FRAME_W-2:0], cfg_bit};
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                        state_d = SETUP;
                    end
`endif
                end
            end
            SETUP: begin
                state_d = WRITE;
            end
            WRITE: begin
                wr_en   = NUM_BLOCKS'(1) << blk_q;
                state_d = HOLD;
            end
            HOLD: begin
                if (blk_q == IDX_W'(NUM_BLOCKS - 1)) begin
                    state_d = DONE;
                end else begin
                    blk_d   = blk_q + IDX_W'(1);
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // busy covers the DONE cycle and drops once the FSM is back in IDLE.
    assign busy = (state_q != IDLE);
    assign bits = bits_q;
`ifdef CFG_PARITY_EN
    assign err  = err_q;
`else
    assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Directed testbench for cfg_frame_loader.
//
// Stimulus timing:
//   - Inputs change 1 time unit after a rising edge.
//   - Outputs are sampled at that same point. They reflect the state entered
//     on that edge.
//
// Cycle counting:
//   - `cyc` counts edges after the edge that accepts start.
//   - done is expected once NUM_BLOCKS*PER_BLK edges have passed. That is the
//     85th cycle of a load in the default build.
module tb_cfg_frame_loader;

    localparam int NB = 4;
    localparam int FW = 18;
`ifdef CFG_PARITY_EN
    localparam int PER_BLK = FW + 4;
`else
    localparam int PER_BLK = FW + 3;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_bit = 1'b0;
    logic          cfg_ready;
    logic [FW-1:0] bits;
    logic [NB-1:0] wr_en;
    logic          busy;
    logic          done;
    logic          err;

    cfg_frame_loader #(.NUM_BLOCKS(NB), .FRAME_W(FW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .bits      (bits),
        .wr_en     (wr_en),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int viol     = 0;
    int wr_cnt[NB];

    logic [FW-1:0] frames[NB] = '{18'h2AAAA, 18'h15555, 18'h3FFFF, 18'h00001};

    // Advance one cycle and record the events the scenarios check.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (done === 1'b1) done_cnt++;
        if (wr_en !== '0 && cfg_ready === 1'b1) viol++;
        for (int i = 0; i < NB; i++) if (wr_en[i] === 1'b1) wr_cnt[i]++;
    endtask

    task automatic clear_stats();
        done_cnt = 0;
        viol     = 0;
        for (int i = 0; i < NB; i++) wr_cnt[i] = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        cyc   = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Shift one frame MSB first.
    // stall: insert a cfg_valid=0 cycle before every bit. The stall cycle
    //   drives the wrong bit value, so a stall that leaks a shift is visible.
    // mid_start: pulse start partway through the frame.
    // par: the parity bit sent after the frame (parity build only).
    task automatic send_frame(input logic [FW-1:0] frame, input bit stall,
                              input bit mid_start, input logic par);
        for (int i = FW - 1; i >= 0; i--) begin
            if (stall) begin
                cfg_valid = 1'b0;
                cfg_bit   = ~frame[i];
                step();
            end
            cfg_valid = 1'b1;
            cfg_bit   = frame[i];
            if (mid_start && i == 12) start = 1'b1;
            step();
            start = 1'b0;
        end
`ifdef CFG_PARITY_EN
        cfg_valid = 1'b1;
        cfg_bit   = par;
        step();
`else
        if (par === 1'bx) cfg_bit = 1'b0;
`endif
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        step();
        step();
        checks++;
        if (bits !== '0) begin
            failures++;
            $display("FAIL reset_bits got=%h exp=0", bits);
        end
        checks++;
        if (wr_en !== '0) begin
            failures++;
            $display("FAIL reset_wr_en got=%b exp=0", wr_en);
        end
        checks++;
        if ({cfg_ready, busy, done, err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got ready/busy/done/err=%b exp=0000",
                     {cfg_ready, busy, done, err});
        end
        rst_n = 1'b1;
        start = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_busy got=%b exp=0", busy);
        end
        do_start();
        checks++;
        if (busy !== 1'b1 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_busy got busy=%b ready=%b exp=1 1", busy, cfg_ready);
        end
        do_reset();
    endtask

    task automatic test_full_load();
        clear_stats();
        do_start();
        for (int k = 0; k < NB; k++) begin
            send_frame(frames[k], 1'b0, 1'b0, ^frames[k]);
            checks++;
            if (bits !== frames[k] || wr_en !== '0 || cfg_ready !== 1'b0) begin
                failures++;
                $display("FAIL setup_blk%0d got bits=%h wr_en=%b ready=%b exp bits=%h wr_en=0 ready=0",
                         k, bits, wr_en, cfg_ready, frames[k]);
            end
            step();
            checks++;
            if (wr_en !== NB'(1 << k) || bits !== frames[k]) begin
                failures++;
                $display("FAIL write_blk%0d got wr_en=%b bits=%h exp wr_en=%b bits=%h",
                         k, wr_en, bits, NB'(1 << k), frames[k]);
            end
            step();
            checks++;
            if (wr_en !== '0 || bits !== frames[k]) begin
                failures++;
                $display("FAIL hold_blk%0d got wr_en=%b bits=%h exp wr_en=0 bits=%h",
                         k, wr_en, bits, frames[k]);
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || cyc !== NB * PER_BLK || busy !== 1'b1) begin
            failures++;
            $display("FAIL done_timing got done=%b busy=%b edges=%0d exp done=1 busy=1 edges=%0d",
                     done, busy, cyc, NB * PER_BLK);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || bits !== frames[NB-1]) begin
            failures++;
            $display("FAIL after_done got done=%b busy=%b bits=%h exp 0 0 %h",
                     done, busy, bits, frames[NB-1]);
        end
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (wr_cnt[i] !== 1) begin
                failures++;
                $display("FAIL wr_count_blk%0d got=%0d exp=1", i, wr_cnt[i]);
            end
        end
    endtask

    task automatic test_stall();
        clear_stats();
        do_start();
        send_frame(18'h0F0F3, 1'b1, 1'b0, ^18'h0F0F3);
        checks++;
        if (cyc !== 2 * FW + PER_BLK - FW - 3 + 0 || bits !== 18'h0F0F3) begin
            failures++;
            $display("FAIL stall_setup got edges=%0d bits=%h exp edges=%0d bits=0f0f3",
                     cyc, bits, 2 * FW + PER_BLK - FW - 3);
        end
        step();
        checks++;
        if (wr_en !== 4'b0001 || bits !== 18'h0F0F3) begin
            failures++;
            $display("FAIL stall_write got wr_en=%b bits=%h exp 0001 0f0f3", wr_en, bits);
        end
        checks++;
        if (viol !== 0) begin
            failures++;
            $display("FAIL stall_wr_vs_ready got=%0d overlaps exp=0", viol);
        end
        do_reset();
    endtask

    task automatic test_start_busy();
        clear_stats();
        do_start();
        for (int k = 0; k < NB; k++) begin
            send_frame(frames[k], 1'b0, (k == 2), ^frames[k]);
            step();
            step();
            step();
        end
        checks++;
        if (done !== 1'b1 || cyc !== NB * PER_BLK) begin
            failures++;
            $display("FAIL busy_start_done got done=%b edges=%0d exp 1 %0d",
                     done, cyc, NB * PER_BLK);
        end
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (done_cnt !== 1 || wr_cnt[0] !== 1 || wr_cnt[2] !== 1 || wr_cnt[3] !== 1) begin
            failures++;
            $display("FAIL busy_start_counts got done=%0d wr0=%0d wr2=%0d wr3=%0d exp 1 1 1 1",
                     done_cnt, wr_cnt[0], wr_cnt[2], wr_cnt[3]);
        end
    endtask

    task automatic test_reset_mid();
        clear_stats();
        do_start();
        send_frame(frames[0], 1'b0, 1'b0, ^frames[0]);
        step();
        step();
        step();
        send_frame(frames[1], 1'b0, 1'b0, ^frames[1]);
        step();
        checks++;
        if (wr_en !== 4'b0010) begin
            failures++;
            $display("FAIL mid_write_blk1 got=%b exp=0010", wr_en);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (wr_en !== '0 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got wr_en=%b busy=%b ready=%b exp 0 0 0",
                     wr_en, busy, cfg_ready);
        end
        cfg_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cfg_bit = i[0];
            step();
        end
        cfg_valid = 1'b0;
        checks++;
        if (wr_cnt[0] !== 1 || wr_cnt[1] !== 1 || wr_cnt[2] !== 0 || wr_cnt[3] !== 0 ||
            done_cnt !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_quiet got wr=%0d%0d%0d%0d done=%0d busy=%b exp wr=1100 done=0 busy=0",
                     wr_cnt[0], wr_cnt[1], wr_cnt[2], wr_cnt[3], done_cnt, busy);
        end
    endtask

`ifdef CFG_PARITY_EN
    task automatic test_parity();
        clear_stats();
        do_start();
        send_frame(18'h00003, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (wr_en !== 4'b0001) begin
            failures++;
            $display("FAIL par_good_write got=%b exp=0001", wr_en);
        end
        step();
        step();
        send_frame(18'h00001, 1'b0, 1'b0, 1'b0);
        checks++;
        if (err !== 1'b1 || done !== 1'b1 || wr_en !== '0) begin
            failures++;
            $display("FAIL par_bad got err=%b done=%b wr_en=%b exp 1 1 0", err, done, wr_en);
        end
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (wr_cnt[1] !== 0 || wr_cnt[2] !== 0 || wr_cnt[3] !== 0 || done_cnt !== 1 ||
            busy !== 1'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL par_abort got wr1..3=%0d%0d%0d done=%0d busy=%b err=%b exp 000 1 0 1",
                     wr_cnt[1], wr_cnt[2], wr_cnt[3], done_cnt, busy, err);
        end
        do_start();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL par_err_clear got=%b exp=0", err);
        end
        do_reset();
    endtask
`else
    task automatic test_err_tied();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_tied got=%b exp=0", err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_stall();
        test_start_busy();
        test_reset_mid();
`ifdef CFG_PARITY_EN
        test_parity();
`else
        test_err_tied();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
